lane_fifo_scheduler: RTL
========================

LANE_FIFO_SCHEDULER -- requirements
Module: lane_fifo_scheduler

Interface
REQ-001 SHALL have parameter BURST, default 4, meaning the max consecutive pops from one lane when the other lane has data.
REQ-002 SHALL have these ports, each: name, direction, width, meaning.
- clk  input  1  single system clock; all logic on posedge clk.
- reset  input  1  synchronous, active-low reset.
- active  input  1  link aligned (BC alignment achieved); scheduling enabled.
- empty_f1, empty_f2  input  1 each  lane FIFO empty flags.
- almost_full_f1, almost_full_f2  input  1 each  lane FIFO almost-full flags.
- data_f1, data_f2  input  8 each  lane FIFO read data, valid the cycle after the corresponding pop.
- down_almost_full  input  1  downstream FIFO almost full; it guarantees at least 2 free entries.
- pop_f1, pop_f2  output  1 each  lane FIFO read strobes.
- push_out  output  1  downstream write strobe.
- data_out  output  8  downstream write data.
- lane_id  output  1  source of data_out: 0 = f1, 1 = f2.
- state  output  2  current FSM state.

Function
REQ-003 SHALL implement the FSM states RESET=0, INIT=1, IDLE=2, ACTIVE=3 and drive state with the registered encoding.
REQ-004 SHALL move RESET->INIT on the first clk with reset=1, and INIT->IDLE after exactly one cycle; INIT clears the burst counter and sets the round-robin pointer to f1.
REQ-005 SHALL move IDLE->ACTIVE when active=1, down_almost_full=0, and (empty_f1=0 or empty_f2=0); no pop is issued in IDLE.
REQ-006 SHALL move ACTIVE->IDLE when active=0, or both FIFOs are empty with no pop issued that cycle.
REQ-007 SHALL, in ACTIVE, assert at most one of pop_f1/pop_f2 per cycle, combinationally from the current inputs.
REQ-008 SHALL never pop a lane whose empty flag is 1, and SHALL issue no pop while down_almost_full=1.
REQ-009 SHALL select the lane as follows: if exactly one eligible (non-empty) lane has almost_full=1, serve it; otherwise serve the current lane until BURST consecutive pops, then switch to the other lane if it is non-empty.
REQ-010 SHALL keep serving the current lane past BURST when the other lane is empty.
REQ-011 SHALL use a 3-bit burst counter that increments per pop of the current lane and clears to 1 on a lane switch.
REQ-012 SHALL, one cycle after pop_fN, assert push_out=1 with data_out=data_fN and lane_id=N-1; pop-to-push latency is exactly 1 cycle.
REQ-013 SHALL sustain back-to-back pops at 1 word/cycle (pipelined).
REQ-014 SHALL complete an in-flight push even if down_almost_full, active, or the state changes in the pop cycle.
REQ-015 SHALL keep data_out and lane_id at their last values, with push_out=0, when no push occurs.
REQ-016 SHALL give the almost_full override priority over the burst limit and, when the override switches lanes, clear the burst counter as on a normal switch.

Reset
REQ-017 SHALL, on a clk edge with reset=0, drive state=RESET, pop_f1=pop_f2=0, push_out=0, data_out=8'h00, lane_id=0, burst counter=0, and RR pointer=f1.
REQ-018 SHALL hold pops at 0 combinationally while reset=0.
REQ-019 SHALL drop any push pending from a pop in the cycle before reset asserts.
REQ-020 SHALL treat reset mid-ACTIVE identically to power-on reset.

Configuration
REQ-021 SHALL, with macro SCHED_STATS_EN defined, add outputs cnt_f1[15:0] and cnt_f2[15:0]: saturating counts of words pushed per lane, cleared by reset.
REQ-022 SHALL, without SCHED_STATS_EN, omit those ports and counters, with all other behaviour identical.

Verification
REQ-023 SHALL cover: reset=0 for 6 clks then 1 -> state sequence 0,1,2; all outputs 0 throughout reset.
REQ-024 SHALL cover: active=1, f1 holds 8'hFF,8'hDD and f2 empty -> pop_f1 on 2 consecutive cycles; push_out on the next 2 cycles with data_out FF then DD, lane_id=0; return to IDLE.
REQ-025 SHALL cover: both lanes holding 6 words, BURST=4 -> pop order f1 x4, f2 x4, f1 x2, f2 x2.
REQ-026 SHALL cover: f2 almost_full=1 in the middle of an f1 burst -> the next pop is f2, and the burst counter restarts.
REQ-027 SHALL cover: down_almost_full=1 on the cycle after pop_f1 -> the pending push still occurs and no further pops occur until it drops.
REQ-028 SHALL cover: reset=0 the cycle after a pop -> no push_out, with state=RESET at the next edge.

Source files
------------

// File: rtl/lane_fifo_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo_scheduler_if
// Description : Bundle of every signal between the two-lane scheduler and
//               its environment (lane FIFOs, downstream FIFO, link status).
//   Link / status inputs : active, down_almost_full
//   Lane FIFO inputs     : empty_f1/f2, almost_full_f1/f2, data_f1/f2[7:0]
//   Lane FIFO outputs    : pop_f1, pop_f2
//   Downstream outputs   : push_out, data_out[7:0], lane_id
//   Status output        : state[1:0]
//   Optional (SCHED_STATS_EN) : cnt_f1[15:0], cnt_f2[15:0]
//   Modports: master = scheduler side, slave = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_fifo_scheduler_if;
  logic       active;
  logic       empty_f1;
  logic       empty_f2;
  logic       almost_full_f1;
  logic       almost_full_f2;
  logic [7:0] data_f1;
  logic [7:0] data_f2;
  logic       down_almost_full;
  logic       pop_f1;
  logic       pop_f2;
  logic       push_out;
  logic [7:0] data_out;
  logic       lane_id;
  logic [1:0] state;
`ifdef SCHED_STATS_EN
  logic [15:0] cnt_f1;
  logic [15:0] cnt_f2;

  modport master (
    input  active, empty_f1, empty_f2, almost_full_f1, almost_full_f2,
           data_f1, data_f2, down_almost_full,
    output pop_f1, pop_f2, push_out, data_out, lane_id, state,
           cnt_f1, cnt_f2
  );
  modport slave (
    output active, empty_f1, empty_f2, almost_full_f1, almost_full_f2,
           data_f1, data_f2, down_almost_full,
    input  pop_f1, pop_f2, push_out, data_out, lane_id, state,
           cnt_f1, cnt_f2
  );
`else
  modport master (
    input  active, empty_f1, empty_f2, almost_full_f1, almost_full_f2,
           data_f1, data_f2, down_almost_full,
    output pop_f1, pop_f2, push_out, data_out, lane_id, state
  );
  modport slave (
    output active, empty_f1, empty_f2, almost_full_f1, almost_full_f2,
           data_f1, data_f2, down_almost_full,
    input  pop_f1, pop_f2, push_out, data_out, lane_id, state
  );
`endif
endinterface
`default_nettype wire

// File: rtl/lane_fifo_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : lane_fifo_scheduler
// Description : Drains two lane FIFOs into one downstream FIFO. Lanes are
//               served in bursts of up to BURST words (round robin); a lane
//               that is almost full and non-empty pre-empts the burst. Pops
//               are combinational, the downstream push follows one cycle
//               later carrying the lane FIFO's read data.
// Ports       : clk   - system clock (posedge)
//               reset - synchronous, active-low reset
//               bus   - lane_fifo_scheduler_if.master (see interface header)
// Parameters  : BURST - max consecutive pops from one lane while the other
//                       lane has data (1..7, held in a 3-bit counter)
// Options     : SCHED_STATS_EN - adds saturating per-lane push counters
//                                bus.cnt_f1 / bus.cnt_f2
// Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo_scheduler #(
  parameter int BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  lane_fifo_scheduler_if.master bus
);

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_INIT   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] ST_ACTIVE = 2'd3;

  localparam logic [2:0] C_BURST   = 3'(BURST);
  localparam logic [2:0] C_CNT_MAX = 3'd7;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0] r_state;
  logic [2:0] r_burst;      // pops taken from the current lane in this burst
  logic       r_rr;         // current lane: 0 = f1, 1 = f2
  logic       r_pend;       // a pop was issued last cycle
  logic       r_pend_lane;  // lane of that pop
  logic [7:0] r_last_data;  // data_out held between pushes
  logic       r_last_lane;  // lane_id held between pushes

  // --------------------------------------------------------------------------
  // Lane selection
  // --------------------------------------------------------------------------
  logic w_ne1;
  logic w_ne2;
  logic w_urg1;
  logic w_urg2;
  logic w_cur_ne;
  logic w_oth_ne;
  logic w_pop_ok;
  logic w_pop_lane;
  logic w_switch;

  assign w_ne1    = ~bus.empty_f1;
  assign w_ne2    = ~bus.empty_f2;
  assign w_urg1   = w_ne1 & bus.almost_full_f1;
  assign w_urg2   = w_ne2 & bus.almost_full_f2;
  assign w_cur_ne = r_rr ? w_ne2 : w_ne1;
  assign w_oth_ne = r_rr ? w_ne1 : w_ne2;

  // Pops are gated by reset directly so they fall the moment reset drops,
  // not one edge later.
  assign w_pop_ok = reset & (r_state == ST_ACTIVE) & bus.active &
                    ~bus.down_almost_full & (w_ne1 | w_ne2);

  always_comb begin
    w_pop_lane = r_rr;
    if (w_urg1 ^ w_urg2) begin
      // Exactly one urgent lane: it wins regardless of the burst count.
      w_pop_lane = w_urg2;
    end else if (w_cur_ne && ((r_burst < C_BURST) || !w_oth_ne)) begin
      // Stay on the current lane while the burst lasts, or indefinitely
      // while the other lane has nothing to give.
      w_pop_lane = r_rr;
    end else begin
      // Burst exhausted or current lane empty; w_pop_ok guarantees the
      // other lane has data whenever this branch leads to a pop.
      w_pop_lane = ~r_rr;
    end
  end

  assign w_switch   = (w_pop_lane != r_rr);
  assign bus.pop_f1 = w_pop_ok & ~w_pop_lane;
  assign bus.pop_f2 = w_pop_ok &  w_pop_lane;

  // --------------------------------------------------------------------------
  // Push side: lane FIFO read data arrives the cycle after the pop and is
  // forwarded straight through, so the push lands exactly one cycle after
  // the pop. A push whose cycle sees reset low is discarded.
  // --------------------------------------------------------------------------
  logic       w_push;
  logic [7:0] w_push_data;

  assign w_push       = r_pend & reset;
  assign w_push_data  = r_pend_lane ? bus.data_f2 : bus.data_f1;
  assign bus.push_out = w_push;
  assign bus.data_out = w_push ? w_push_data : r_last_data;
  assign bus.lane_id  = w_push ? r_pend_lane : r_last_lane;
  assign bus.state    = r_state;

  // --------------------------------------------------------------------------
  // FSM, burst counter and push pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_RESET;
      r_burst     <= 3'd0;
      r_rr        <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_lane <= 1'b0;
      r_last_data <= 8'h00;
      r_last_lane <= 1'b0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_state <= ST_INIT;
        end
        ST_INIT: begin
          r_state <= ST_IDLE;
          r_burst <= 3'd0;
          r_rr    <= 1'b0;
        end
        ST_IDLE: begin
          if (bus.active && !bus.down_almost_full && (w_ne1 || w_ne2)) begin
            r_state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Both lanes empty implies no pop this cycle.
          if (!bus.active || (!w_ne1 && !w_ne2)) begin
            r_state <= ST_IDLE;
          end
          if (w_pop_ok) begin
            if (w_switch) begin
              r_rr    <= w_pop_lane;
              r_burst <= 3'd1;
            end else if (r_burst != C_CNT_MAX) begin
              // Saturate: a lane served alone past BURST must not wrap
              // the count back into a fresh burst.
              r_burst <= r_burst + 3'd1;
            end
          end
        end
        default: begin
          r_state <= ST_RESET;
        end
      endcase

      r_pend      <= w_pop_ok;
      r_pend_lane <= w_pop_lane;
      if (w_push) begin
        r_last_data <= w_push_data;
        r_last_lane <= r_pend_lane;
      end
    end
  end

`ifdef SCHED_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating per-lane push counters
  // --------------------------------------------------------------------------
  logic [15:0] r_cnt_f1;
  logic [15:0] r_cnt_f2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt_f1 <= 16'h0000;
      r_cnt_f2 <= 16'h0000;
    end else if (w_push) begin
      if (!r_pend_lane && (r_cnt_f1 != 16'hFFFF)) begin
        r_cnt_f1 <= r_cnt_f1 + 16'h0001;
      end
      if (r_pend_lane && (r_cnt_f2 != 16'hFFFF)) begin
        r_cnt_f2 <= r_cnt_f2 + 16'h0001;
      end
    end
  end

  assign bus.cnt_f1 = r_cnt_f1;
  assign bus.cnt_f2 = r_cnt_f2;
`endif

endmodule
`default_nettype wire
